// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel-tick input and raster outputs of the VGA timing generator.
interface vga_sync_gen_if;
    logic        pix_en;
    logic [10:0] Columnas;
    logic [9:0]  Filas;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        frame_start;
    modport master (
        input  pix_en,
        output Columnas, Filas, hsync, vsync, video_on, frame_start
    );
    modport slave (
        output pix_en,
        input  Columnas, Filas, hsync, vsync, video_on, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters (Columnas/Filas), active-low sync decode, video_on window and frame_start pulse.
// Optional macro VGA_SYNC_DELAY_EN: hsync/vsync/video_on pass through one pix_en-enabled register stage.
module vga_sync_gen #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SW    = 11'(H_SYNC);
    localparam logic [9:0]  V_SW    = 10'(V_SYNC);
    localparam logic [10:0] H_VLO   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VHI   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_VLO   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VHI   = 10'(V_SYNC + V_BP + V_ACTIVE);

    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        fs_q, fs_d;
    logic        hs_c, vs_c, von_c;
    logic        line_end, frame_end;

    assign line_end  = col_q == H_LAST;
    assign frame_end = line_end && (row_q == V_LAST);

    // Next raster position and frame_start; everything holds when no pixel tick.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        fs_d  = 1'b0;
        if (bus.pix_en) begin
            col_d = line_end ? 11'd0 : col_q + 11'd1;
            row_d = !line_end ? row_q : (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
            fs_d  = frame_end;
        end
    end

    // Counter and frame_start registers; reset restarts the raster without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            fs_q  <= fs_d;
        end
    end

    // Zero-latency decode of the current counters.
    always_comb begin
        hs_c  = !(col_q < H_SW);
        vs_c  = !(row_q < V_SW);
        von_c = (col_q >= H_VLO) && (col_q < H_VHI) && (row_q >= V_VLO) && (row_q < V_VHI);
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_q, hs_d, vs_q, vs_d, von_q, von_d;

    // Delay stage advances with the counters to line up with a 1-tick ROM read.
    always_comb begin
        hs_d  = bus.pix_en ? hs_c  : hs_q;
        vs_d  = bus.pix_en ? vs_c  : vs_q;
        von_d = bus.pix_en ? von_c : von_q;
    end

    // Delay registers clear to inactive-window, sync-asserted on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            von_q <= 1'b0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
        end
    end

    assign bus.hsync    = hs_q;
    assign bus.vsync    = vs_q;
    assign bus.video_on = von_q;
`else
    assign bus.hsync    = hs_c;
    assign bus.vsync    = vs_c;
    assign bus.video_on = von_c;
`endif

    assign bus.Columnas    = col_q;
    assign bus.Filas       = row_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks full-size and shrunken-timing instances against a reference raster model.
module tb_vga_sync_gen;
    typedef struct packed {
        logic [10:0] col;
        logic [9:0]  row;
        logic        hs, vs, von, fs;
    } obs_t;
    typedef struct {
        int hs, hlo, hhi, ht, vs, vlo, vhi, vt;
    } cfg_t;
    typedef struct {
        logic rst, pe;
        int   col, row;
        logic fs;
    } vec_t;

`ifdef VGA_SYNC_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();

    vga_sync_gen dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    vga_sync_gen #(
        .H_SYNC(3), .H_BP(2), .H_ACTIVE(5), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .V_FP(1)
    ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    cfg_t     cfg [2];
    int       m_col [2], m_row [2];
    logic     m_fs [2];
    logic [2:0] m_dl [2];
    obs_t     q [$];
    int       total = 0;
    int       bad = 0;

    function automatic logic [2:0] decode(input cfg_t c, input int col, input int row);
        decode = {col >= c.hs, row >= c.vs,
                  col >= c.hlo && col < c.hhi && row >= c.vlo && row < c.vhi};
    endfunction

    task automatic observe(input int w, output obs_t g);
        if (w == 0) g = '{bus_a.Columnas, bus_a.Filas, bus_a.hsync, bus_a.vsync, bus_a.video_on, bus_a.frame_start};
        else        g = '{bus_b.Columnas, bus_b.Filas, bus_b.hsync, bus_b.vsync, bus_b.video_on, bus_b.frame_start};
    endtask

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    // Drive one clock of stimulus, push the model's expectation, then pop and compare.
    task automatic step(input int w, input logic r, input logic pe, input string n);
        obs_t e, g;
        logic [2:0] d;
        if (w == 0) begin rst_a = r; bus_a.pix_en = pe; end
        else        begin rst_b = r; bus_b.pix_en = pe; end
        d = decode(cfg[w], m_col[w], m_row[w]);
        if (r) begin
            m_col[w] = 0; m_row[w] = 0; m_fs[w] = 1'b0; m_dl[w] = 3'b000;
        end else if (pe) begin
            m_dl[w] = d;
            m_fs[w] = (m_col[w] == cfg[w].ht - 1) && (m_row[w] == cfg[w].vt - 1);
            if (m_col[w] == cfg[w].ht - 1) begin
                m_col[w] = 0;
                m_row[w] = (m_row[w] == cfg[w].vt - 1) ? 0 : m_row[w] + 1;
            end else m_col[w] = m_col[w] + 1;
        end else m_fs[w] = 1'b0;
        d = DLY ? m_dl[w] : decode(cfg[w], m_col[w], m_row[w]);
        q.push_back('{11'(m_col[w]), 10'(m_row[w]), d[2], d[1], d[0], m_fs[w]});
        @(posedge clk);
        #1;
        observe(w, g);
        e = q.pop_front();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got col=%0d row=%0d hs=%b vs=%b von=%b fs=%b expected col=%0d row=%0d hs=%b vs=%b von=%b fs=%b",
                     n, g.col, g.row, g.hs, g.vs, g.von, g.fs, e.col, e.row, e.hs, e.vs, e.von, e.fs);
        end
    endtask

    task automatic run_to(input int w, input int col, input int row, input string n);
        obs_t g;
        for (int k = 0; k < 50000 && !(m_col[w] == col && m_row[w] == row); k++) step(w, 1'b0, 1'b1, n);
        observe(w, g);
        chk({n, "_reach"}, {g.col, g.row}, {col[10:0], row[9:0]});
    endtask

    initial begin
        vec_t tv [18];
        obs_t g;
        int   n_fs, n_hl, n_vl, per;
        cfg[0] = '{128, 216, 1016, 1056, 2, 35, 635, 636};
        cfg[1] = '{3, 5, 10, 12, 2, 3, 6, 7};
        for (int w = 0; w < 2; w++) begin
            m_col[w] = 0; m_row[w] = 0; m_fs[w] = 1'b0; m_dl[w] = 3'b000;
        end
        rst_a = 1'b1; rst_b = 1'b1; bus_a.pix_en = 1'b0; bus_b.pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        tv[0]  = '{1'b1, 1'b1, 0, 0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 0, 0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 0, 0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1, 0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1, 0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 2, 0, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 3, 0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 4, 0, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 4, 0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 5, 0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 6, 0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 7, 0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 8, 0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 9, 0, 1'b0};
        tv[14] = '{1'b0, 1'b1, 10, 0, 1'b0};
        tv[15] = '{1'b0, 1'b1, 11, 0, 1'b0};
        tv[16] = '{1'b0, 1'b1, 0, 1, 1'b0};
        tv[17] = '{1'b0, 1'b1, 1, 1, 1'b0};
        for (int i = 0; i < 18; i++) begin
            step(1, tv[i].rst, tv[i].pe, "tbl");
            observe(1, g);
            chk($sformatf("tbl%0d_cnt", i), {g.col, g.row, g.fs}, {tv[i].col[10:0], tv[i].row[9:0], tv[i].fs});
        end

        step(1, 1'b1, 1'b1, "b_rst");
        n_fs = 0; n_hl = 0; n_vl = 0;
        for (int i = 0; i < 84; i++) begin
            step(1, 1'b0, 1'b1, "b_frame");
            observe(1, g);
            n_fs += int'(g.fs);
            n_hl += int'(!g.hs);
            n_vl += int'(!g.vs);
            if (m_col[1] == 5 && m_row[1] == 3) chk("b_von_5_3", g.von, DLY ? 0 : 1);
            if (m_col[1] == 10 && m_row[1] == 3) chk("b_von_10_3", g.von, DLY ? 1 : 0);
            if (m_col[1] == 5 && m_row[1] == 6) chk("b_von_5_6", g.von, 0);
        end
        chk("b_fs_count", n_fs, 1);
        chk("b_hsync_low", n_hl, 7 * 3);
        chk("b_vsync_low", n_vl, 2 * 12);
        observe(1, g);
        chk("b_wrap", {g.col, g.row, g.fs}, {11'd0, 10'd0, 1'b1});

        for (int p = 0; p < 2; p++) begin
            per = 0;
            for (int k = 0; k < 400; k++) begin
                step(1, 1'b0, k[0], "b_toggle");
                per++;
                observe(1, g);
                if (g.fs) break;
            end
            chk($sformatf("b_toggle_period%0d", p), per, 2 * 84);
        end

        run_to(1, 6, 4, "b_mid");
        step(1, 1'b1, 1'b1, "b_mid_rst");
        observe(1, g);
        chk("b_mid_rst", {g.col, g.row, g.fs}, 0);
        step(1, 1'b0, 1'b1, "b_resume");
        observe(1, g);
        chk("b_resume", g.col, 1);
        bus_b.pix_en = 1'b0;

        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, "a_rst");
        observe(0, g);
        chk("a_rst_state", g, 0);
        run_to(0, 127, 0, "a_h127");
        chk("a_hs_127", g.hs, 0);
        step(0, 1'b0, 1'b1, "a_h128");
        run_to(0, 215, 35, "a_215_35");
        observe(0, g);
        chk("a_von_215_35", g.von, 0);
        step(0, 1'b0, 1'b1, "a_216_35");
        observe(0, g);
        chk("a_von_216_35", g.von, DLY ? 0 : 1);
        run_to(0, 1015, 35, "a_1015_35");
        observe(0, g);
        chk("a_von_1015_35", g.von, 1);
        step(0, 1'b0, 1'b1, "a_1016_35");
        observe(0, g);
        chk("a_von_1016_35", g.von, DLY ? 1 : 0);
        step(0, 1'b1, 1'b0, "a_mid_rst");
        observe(0, g);
        chk("a_mid_rst", {g.col, g.row, g.fs}, 0);
        step(0, 1'b0, 1'b1, "a_resume");
        observe(0, g);
        chk("a_resume", {g.col, g.row}, {11'd1, 10'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
